// File: rtl/bcd_seq_convert_if.sv
// Start/busy/done handshake and digit bus for the sequential binary-to-BCD converter.
interface bcd_seq_convert_if #(
  parameter int WIDTH = 14
);
  logic             start;
  logic [WIDTH-1:0] bin;
  logic             busy;
  logic             done;
  logic [3:0]       bcd_u;
  logic [3:0]       bcd_t;
  logic [3:0]       bcd_h;
  logic [3:0]       bcd_th;
  logic [3:0]       bcd_tt;

  modport master (
    output start, bin,
    input  busy, done, bcd_u, bcd_t, bcd_h, bcd_th, bcd_tt
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd_u, bcd_t, bcd_h, bcd_th, bcd_tt
  );
endinterface

// File: rtl/bcd_seq_convert.sv
// Iterative double-dabble binary-to-BCD converter, WIDTH cycles per conversion.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits with 4'hF.
module bcd_seq_convert #(
  parameter int WIDTH = 14
) (
  input  logic               clk,
  input  logic               reset,
  bcd_seq_convert_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [19:0] RST_DIGITS = 20'hFFFF0;
`else
  localparam logic [19:0] RST_DIGITS = 20'h00000;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [19:0]      scratch;
  logic [19:0]      adj;
  logic [19:0]      next_scratch;
  logic [CW-1:0]    cnt;
  logic [19:0]      digits;
  logic             busy;
  logic             done;

  // All nibbles are corrected in parallel, then the pair shifts left as one.
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    next_scratch = {adj[18:0], shreg[WIDTH-1]};
  end

  function automatic logic [19:0] format_digits(input logic [19:0] s);
    logic [19:0] r;
    r = s;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int unsigned i = 4; i > 0; i--) begin
        if (lead && (s[4*i +: 4] == 4'h0)) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      digits  <= RST_DIGITS;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (bus.start) begin
            shreg   <= bus.bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH - 1);
            busy    <= 1'b1;
            state   <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          scratch <= next_scratch;
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          if (cnt == '0) begin
            digits <= format_digits(next_scratch);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.bcd_u  = digits[3:0];
  assign bus.bcd_t  = digits[7:4];
  assign bus.bcd_h  = digits[11:8];
  assign bus.bcd_th = digits[15:12];
  assign bus.bcd_tt = digits[19:16];
endmodule
